// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler: packs a UART byte stream into {cmd, payload} frames
// and queues the completed frames for the command processor. A partial
// frame that stalls for TIMEOUT_CYC idle cycles is dropped.
module uart_frame_assembler #(
  parameter int DATA_BYTES  = 2,
  parameter int FIFO_DEPTH  = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_rdy,
  input  logic [7:0]                      rx_data,
  output logic                            clr_rx_rdy,
  output logic                            cmd_rdy,
  output logic [7:0]                      cmd,
  output logic [8*DATA_BYTES-1:0]         data,
  input  logic                            clr_cmd_rdy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] frames,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int PW = 8 * DATA_BYTES;
  localparam int FW = PW + 8;
  localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      cmd_q;
  logic [PW-1:0]   payload_q;
  logic [PW-1:0]   payload_nxt;
  logic            push;
  logic            tmo_fire;
  logic [FW-1:0]   push_word;

  logic [FW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [FW-1:0]   hold_q;
  logic [FW-1:0]   head;
  logic            pop;
  logic            full;
  logic            do_push;

  // The UART is never back-pressured: every offered byte is consumed.
  assign clr_rx_rdy = rx_rdy;

  // Byte shift, frame completion and timeout detection.
  always_comb begin
    payload_nxt = (payload_q << 8) | PW'(rx_data);
    push        = (state == PAYLOAD) && rx_rdy && (idx == IDX_LAST);
    push_word   = {cmd_q, payload_nxt};
    tmo_fire    = (TIMEOUT_CYC != 0) && (state == PAYLOAD) && !rx_rdy &&
                  (tmo_cnt == TMO_LAST);
  end

  // Frame assembly FSM with idle timeout and registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      tmo_cnt   <= '0;
      cmd_q     <= '0;
      payload_q <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (rx_rdy) begin
            cmd_q <= rx_data;
            idx   <= '0;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (rx_rdy) begin
            payload_q <= payload_nxt;
            tmo_cnt   <= '0;
            idx       <= idx + 1'b1;
            if (idx == IDX_LAST) state <= IDLE;
          end else if (tmo_fire) begin
            tmo_cnt   <= '0;
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (TIMEOUT_CYC != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A pop needs a stored frame; a push into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    pop     = clr_cmd_rdy && (count != '0);
    full    = (count == CNT_FULL);
    do_push = push && (!full || pop);
  end

  // Frame FIFO storage, pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < unsigned'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hold_q   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (do_push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        hold_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Once empty, the outputs keep showing the frame that was popped last.
  always_comb begin
    head    = (count != '0) ? mem[rd_ptr] : hold_q;
    cmd     = head[FW-1 -: 8];
    data    = head[PW-1:0];
    cmd_rdy = (count != '0);
    frames  = count;
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Self-checking bench for uart_frame_assembler: a 2-byte-payload instance
// with a short timeout, plus a 4-byte-payload instance for width and reset.
module tb_uart_frame_assembler;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic        rx_rdy      = 1'b0;
  logic [7:0]  rx_data     = '0;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy, cmd_rdy, frame_err, overflow;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic [1:0]  frames;

  logic        rx_rdy4      = 1'b0;
  logic [7:0]  rx_data4     = '0;
  logic        clr_cmd_rdy4 = 1'b0;
  logic        clr_rx_rdy4, cmd_rdy4, frame_err4, overflow4;
  logic [7:0]  cmd4;
  logic [31:0] data4;
  logic [2:0]  frames4;

  uart_frame_assembler #(.DATA_BYTES(2), .FIFO_DEPTH(2), .TIMEOUT_CYC(100)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .clr_cmd_rdy(clr_cmd_rdy), .frames(frames), .frame_err(frame_err),
    .overflow(overflow)
  );

  uart_frame_assembler #(.DATA_BYTES(4), .FIFO_DEPTH(4), .TIMEOUT_CYC(100)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy4), .rx_data(rx_data4),
    .clr_rx_rdy(clr_rx_rdy4), .cmd_rdy(cmd_rdy4), .cmd(cmd4), .data(data4),
    .clr_cmd_rdy(clr_cmd_rdy4), .frames(frames4), .frame_err(frame_err4),
    .overflow(overflow4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  c;
    logic [15:0] d;
  } frame_t;

  typedef struct {
    logic [7:0]  c;
    logic [7:0]  p0;
    logic [7:0]  p1;
    int          gap;
    logic        pop_last;
    logic [1:0]  efr;
    logic        eovf;
    logic        drain;
    logic [7:0]  ecmd;
    logic [15:0] edata;
  } vec_t;

  frame_t sb[$];
  frame_t last_popped;
  vec_t   vecs[6];

  int n_checks   = 0;
  int n_fail     = 0;
  int err_pulses = 0;
  int ovf_pulses = 0;

  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (overflow)  ovf_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pop);
    rx_rdy      = 1'b1;
    rx_data     = b;
    clr_cmd_rdy = pop;
    @(negedge clk);
    chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(1));
    @(posedge clk);
    #1;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    rx_rdy4  = 1'b1;
    rx_data4 = b;
    @(posedge clk);
    #1;
    rx_rdy4 = 1'b0;
  endtask

  task automatic pop_check();
    frame_t e;
    e = sb.pop_front();
    chk("cmd_rdy_before_pop", 32'(cmd_rdy), 32'(1));
    chk("pop_cmd", 32'(cmd), 32'(e.c));
    chk("pop_data", 32'(data), 32'(e.d));
    last_popped = e;
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic drain_all();
    while (sb.size() > 0) pop_check();
    chk("empty_cmd_rdy", 32'(cmd_rdy), 32'(0));
    chk("empty_frames", 32'(frames), 32'(0));
    chk("hold_cmd", 32'(cmd), 32'(last_popped.c));
    chk("hold_data", 32'(data), 32'(last_popped.d));
  endtask

  initial begin
    frame_t e;
    //          c      p0     p1     gap pop   efr   ovf   drain ecmd   edata
    vecs[0] = '{8'h05, 8'hAB, 8'hCD, 20, 1'b0, 2'd1, 1'b0, 1'b0, 8'h05, 16'hABCD};
    vecs[1] = '{8'h12, 8'h34, 8'h56, 0,  1'b0, 2'd2, 1'b0, 1'b0, 8'h12, 16'h3456};
    vecs[2] = '{8'h78, 8'h9A, 8'hBC, 3,  1'b0, 2'd2, 1'b1, 1'b1, 8'h78, 16'h9ABC};
    vecs[3] = '{8'h3C, 8'h5A, 8'hA5, 1,  1'b1, 2'd1, 1'b0, 1'b0, 8'h3C, 16'h5AA5};
    vecs[4] = '{8'hE1, 8'h0F, 8'hF0, 0,  1'b0, 2'd2, 1'b0, 1'b0, 8'hE1, 16'h0FF0};
    vecs[5] = '{8'h99, 8'h88, 8'h77, 2,  1'b1, 2'd2, 1'b0, 1'b1, 8'h99, 16'h8877};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'(0));
    chk("rst_cmd", 32'(cmd), 32'(0));
    chk("rst_data", 32'(data), 32'(0));
    chk("rst_frames", 32'(frames), 32'(0));
    chk("rst_frame_err", 32'(frame_err), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'(0));
    rst_n = 1'b1;
    idle(1);

    // Table: normal frames, fill/overflow, push+pop on empty and on full
    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].c, 1'b0);
      idle(vecs[i].gap);
      send_byte(vecs[i].p0, 1'b0);
      idle(vecs[i].gap);
      chk("frames_pre", 32'(frames), 32'(sb.size()));
      chk("cmd_rdy_pre", 32'(cmd_rdy), 32'(sb.size() != 0));
      if (vecs[i].pop_last && sb.size() > 0) begin
        e = sb.pop_front();
        chk("simul_pop_cmd", 32'(cmd), 32'(e.c));
        chk("simul_pop_data", 32'(data), 32'(e.d));
        last_popped = e;
      end
      send_byte(vecs[i].p1, vecs[i].pop_last);
      chk("frames_post", 32'(frames), 32'(vecs[i].efr));
      chk("overflow_post", 32'(overflow), 32'(vecs[i].eovf));
      chk("cmd_rdy_post", 32'(cmd_rdy), 32'(1));
      chk("frame_err_post", 32'(frame_err), 32'(0));
      if (!vecs[i].eovf) sb.push_back('{vecs[i].ecmd, vecs[i].edata});
      chk("head_cmd", 32'(cmd), 32'(sb[0].c));
      chk("head_data", 32'(data), 32'(sb[0].d));
      if (vecs[i].drain) drain_all();
    end

    // Timeout: 100 idle cycles after the first payload byte discard the frame
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    idle(99);
    chk("tmo_early", 32'(frame_err), 32'(0));
    idle(1);
    chk("tmo_fire", 32'(frame_err), 32'(1));
    chk("tmo_no_push", 32'(frames), 32'(0));
    idle(1);
    chk("tmo_pulse_end", 32'(frame_err), 32'(0));
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    chk("resync_frames", 32'(frames), 32'(1));
    sb.push_back('{8'h33, 16'h4455});
    pop_check();

    // Boundary: byte lands exactly on the would-fire cycle
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    idle(99);
    send_byte(8'h88, 1'b0);
    chk("bnd_frame_err", 32'(frame_err), 32'(0));
    chk("bnd_frames", 32'(frames), 32'(1));
    idle(150);
    chk("bnd_idle_err", 32'(frame_err), 32'(0));
    sb.push_back('{8'h66, 16'h7788});
    pop_check();

    chk("err_pulse_count", 32'(err_pulses), 32'(1));
    chk("ovf_pulse_count", 32'(ovf_pulses), 32'(1));

    // Four payload bytes, then reset during a partial frame
    send4(8'hA0); send4(8'h01); send4(8'h02); send4(8'h03); send4(8'h04);
    chk("db4_frames", 32'(frames4), 32'(1));
    chk("db4_cmd", 32'(cmd4), 32'(8'hA0));
    chk("db4_data", data4, 32'h01020304);
    send4(8'hB0);
    send4(8'h05);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_cmd_rdy4", 32'(cmd_rdy4), 32'(0));
    chk("mid_rst_cmd4", 32'(cmd4), 32'(0));
    chk("mid_rst_data4", data4, 32'(0));
    chk("mid_rst_frames4", 32'(frames4), 32'(0));
    chk("mid_rst_err4", 32'(frame_err4), 32'(0));
    chk("mid_rst_ovf4", 32'(overflow4), 32'(0));
    chk("mid_rst_clr4", 32'(clr_rx_rdy4), 32'(0));
    chk("mid_rst_cmd", 32'(cmd), 32'(0));
    chk("mid_rst_data", 32'(data), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send4(8'hC0); send4(8'h0A); send4(8'h0B); send4(8'h0C); send4(8'h0D);
    chk("post_rst_frames4", 32'(frames4), 32'(1));
    chk("post_rst_cmd4", 32'(cmd4), 32'(8'hC0));
    chk("post_rst_data4", data4, 32'h0A0B0C0D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
